fetch_pair_queue: RTL

- Front-end producer for the dual-issue relayer unit.
- Fetches two 16-bit instructions per request from instruction memory and buffers them in a circular queue.
- Presents the oldest two to the relayer as instr1_o/instr2_o, then retires 0, 1 or 2 of them per cycle according to the relayer's isstall/issingleinstr feedback.
- Handles branch redirect by flushing the queue and discarding the in-flight fetch.

---
 rtl/fetch_pkg.sv | 35 +++
 rtl/pair_fifo.sv | 62 ++++++
 rtl/fetch_pair_queue.sv | 109 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Purpose : shared fetch-side definitions (nop word, opcode field, retire codes, FSM states).
// Latency : n/a (types and constants only).
// Backpressure: n/a. Also consumed by relayer and decode.
package fetch_pkg;

  localparam logic [15:0] NOP     = 16'h0;
  localparam int          OPC_MSB = 15;
  localparam int          OPC_LSB = 12;

  // Number of queued instructions the relayer consumed this cycle.
  typedef enum logic [1:0] {
    RET_0 = 2'd0,
    RET_1 = 2'd1,
    RET_2 = 2'd2
  } ret_e;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_e;

  // Stall wins over single-issue; otherwise both presented words were taken.
  function automatic ret_e ret_decode(input logic stall, input logic single);
    ret_e r;
    if (stall) begin
      r = RET_0;
    end else if (single) begin
      r = RET_1;
    end else begin
      r = RET_2;
    end
    return r;
  endfunction

endpackage

// File: rtl/pair_fifo.sv
// Purpose : 2-write / 2-read circular buffer of 16-bit instruction words.
// Latency : write visible on outputs the cycle after wr_en; reads are combinational.
// Backpressure: none internally; caller keeps count within DEPTH and rd_cnt <= count.
// Ports: clk/rst (sync, active-high), flush (empty the buffer), wr_en + wr_dat (pair in,
//        [15:0] first), rd_cnt (words retired), rd0_dat/rd1_dat (oldest two, NOP if absent),
//        count (occupancy).
module pair_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [31:0]            wr_dat,
  input  logic [1:0]             rd_cnt,
  output logic [15:0]            rd0_dat,
  output logic [15:0]            rd1_dat,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [15:0]   r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW:0]   r_count;
  logic [PW-1:0] w_head1;
  logic [PW-1:0] w_tail1;

  // Pointers are exactly PW bits wide, so +1/+2 wraps modulo DEPTH for free.
  assign w_head1 = r_head + PW'(1);
  assign w_tail1 = r_tail + PW'(1);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head <= r_head + PW'(rd_cnt);
      if (wr_en) begin
        r_tail <= r_tail + PW'(2);
      end
      r_count <= r_count - (PW+1)'(rd_cnt) + (wr_en ? (PW+1)'(2) : '0);
    end
  end

  // Storage is not reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[r_tail]  <= wr_dat[15:0];
      r_mem[w_tail1] <= wr_dat[31:16];
    end
  end

  assign rd0_dat = (r_count != '0)          ? r_mem[r_head]  : NOP;
  assign rd1_dat = (r_count > (PW+1)'(1))   ? r_mem[w_head1] : NOP;
  assign count   = r_count;

endmodule

// File: rtl/fetch_pair_queue.sv
// Purpose : fetches instruction pairs into a queue and presents the oldest two to the relayer.
// Latency : memory response enqueued at the edge after it arrives; outputs combinational from queue.
// Backpressure: requests throttled so queued + in-flight words never exceed DEPTH.
// Ports: clk/rst (sync, active-high); imem_req_o/imem_addr_o out, imem_valid_i/imem_rdata_i in
//        (response one cycle after request); instr1_o/instr2_o oldest two words; isstall /
//        issingleinstr retire feedback; redirect_i/redirect_pc_i branch redirect; count_o occupancy.
module fetch_pair_queue
  import fetch_pkg::*;
#(
  parameter int            DEPTH    = 8,
  parameter int            AW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req_o,
  output logic [AW-1:0]          imem_addr_o,
  input  logic                   imem_valid_i,
  input  logic [31:0]            imem_rdata_i,
  output logic [15:0]            instr1_o,
  output logic [15:0]            instr2_o,
  input  logic                   isstall,
  input  logic                   issingleinstr,
  input  logic                   redirect_i,
  input  logic [AW-1:0]          redirect_pc_i,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e        r_state;
  state_e        w_state_nxt;
  logic [AW-1:0] r_pc;
  logic          r_inflight;
  logic          w_req;
  logic          w_room;
  logic          w_wr_en;
  logic [CW-1:0] w_count;
  ret_e          w_ret_req;
  logic [1:0]    w_ret;
  logic [15:0]   w_rd0;
  logic [15:0]   w_rd1;

  // Reserve space for the pair already in flight plus the one about to be requested.
  assign w_room = (int'(w_count) + (r_inflight ? 4 : 2)) <= DEPTH;

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    case (r_state)
      S_RUN: begin
        w_req = w_room && !redirect_i && !rst;
        if (redirect_i) begin
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // A further redirect here restarts the flush with the newer target.
        w_state_nxt = redirect_i ? S_FLUSH : S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      // w_req is already low on redirect, which drops the pending response.
      r_inflight <= w_req;
      if (redirect_i) begin
        r_pc <= redirect_pc_i;
      end else if (w_req) begin
        r_pc <= r_pc + AW'(2);
      end
    end
  end

  // Only a response to a live request is kept; redirect and flush discard it.
  assign w_wr_en = imem_valid_i && r_inflight && (r_state == S_RUN) && !redirect_i && !rst;

  // Clamp the relayer's retire request to what is actually queued.
  assign w_ret_req = ret_decode(isstall, issingleinstr);
  assign w_ret     = (w_count < CW'(w_ret_req)) ? w_count[1:0] : w_ret_req;

  pair_fifo #(
    .DEPTH (DEPTH)
  ) u_pair_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect_i),
    .wr_en   (w_wr_en),
    .wr_dat  (imem_rdata_i),
    .rd_cnt  (w_ret),
    .rd0_dat (w_rd0),
    .rd1_dat (w_rd1),
    .count   (w_count)
  );

  assign imem_req_o  = w_req;
  assign imem_addr_o = r_pc;
  assign instr1_o    = (r_state == S_RUN) ? w_rd0 : NOP;
  assign instr2_o    = (r_state == S_RUN) ? w_rd1 : NOP;
  assign count_o     = w_count;

endmodule
